// File: rtl/lfsr_stream_gen.sv
// rtl/lfsr_stream_gen.sv - Galois LFSR candidate generator with valid/ready output
module lfsr_stream_gen #(
    parameter int WIDTH        = 64,
    parameter int CNT_WIDTH    = 64,
    parameter int STOP_ON_WRAP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     seed,
    input  logic [WIDTH-1:0]     polynomial,
    input  logic [CNT_WIDTH-1:0] counter_limit,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     lfsr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 out_valid,
    output logic                 done,
    output logic                 wrapped,
    output logic                 zero_seed
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state;
    logic [WIDTH-1:0]     seed_reg;
    logic [WIDTH-1:0]     poly_reg;
    logic [CNT_WIDTH-1:0] limit_reg;
    logic [WIDTH-1:0]     next_lfsr;
    logic                 unused_poly_msb;

    // The top tap is implied by the feedback into bit WIDTH-1, so the mask MSB has no effect.
    assign unused_poly_msb = poly_reg[WIDTH-1];

    // Galois step: shift right, feedback bit XORed into every tapped position.
    always_comb begin
        next_lfsr = '0;
        for (int i = 0; i < WIDTH-1; i++) begin
            next_lfsr[i] = poly_reg[i] ? (lfsr[i+1] ^ lfsr[0]) : lfsr[i+1];
        end
        next_lfsr[WIDTH-1] = lfsr[0];
    end

    // Run control: start/abort handling, handshake-driven stepping and end-of-run detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            lfsr      <= '0;
            count     <= '0;
            seed_reg  <= '0;
            poly_reg  <= '0;
            limit_reg <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            wrapped   <= 1'b0;
            zero_seed <= 1'b0;
        end else if (abort) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            done      <= 1'b0;
            wrapped   <= 1'b0;
            zero_seed <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        seed_reg  <= seed;
                        poly_reg  <= polynomial;
                        limit_reg <= counter_limit;
                        lfsr      <= seed;
                        count     <= '0;
                        wrapped   <= 1'b0;
                        if (seed == '0) begin
                            // An all-zero state never leaves zero; refuse the run outright.
                            state     <= S_DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            zero_seed <= 1'b1;
                        end else begin
                            state     <= S_RUN;
                            out_valid <= 1'b1;
                            done      <= 1'b0;
                            zero_seed <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (out_valid && out_ready) begin
                        if (count == limit_reg) begin
                            // Limit wins over wrap; the last value stays visible on lfsr/count.
                            state     <= S_DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            wrapped   <= 1'b0;
                        end else if ((STOP_ON_WRAP != 0) && (next_lfsr == seed_reg)) begin
                            state     <= S_DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            wrapped   <= 1'b1;
                        end else begin
                            lfsr  <= next_lfsr;
                            count <= count + CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// tb/tb_lfsr_stream_gen.sv - directed self-checking bench for lfsr_stream_gen
module tb_lfsr_stream_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared stimulus for the two 4-bit instances (wrap-stop and free-running).
    logic       start, abort, ready;
    logic [3:0] seed, poly;
    logic [7:0] limit;
    logic [3:0] l4, l4n;
    logic [7:0] c4, c4n;
    logic       v4, d4, w4, z4, v4n, d4n, w4n, z4n;

    logic        start64, abort64, ready64;
    logic [63:0] seed64, poly64, limit64, l64, c64;
    logic        v64, d64, w64, z64;

    lfsr_stream_gen #(.WIDTH(4), .CNT_WIDTH(8), .STOP_ON_WRAP(1)) u4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
        .polynomial(poly), .counter_limit(limit), .out_ready(ready),
        .lfsr(l4), .count(c4), .out_valid(v4), .done(d4), .wrapped(w4), .zero_seed(z4));

    lfsr_stream_gen #(.WIDTH(4), .CNT_WIDTH(8), .STOP_ON_WRAP(0)) u4n (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
        .polynomial(poly), .counter_limit(limit), .out_ready(ready),
        .lfsr(l4n), .count(c4n), .out_valid(v4n), .done(d4n), .wrapped(w4n), .zero_seed(z4n));

    lfsr_stream_gen #(.WIDTH(64), .CNT_WIDTH(64), .STOP_ON_WRAP(0)) u64 (
        .clk(clk), .rst(rst), .start(start64), .abort(abort64), .seed(seed64),
        .polynomial(poly64), .counter_limit(limit64), .out_ready(ready64),
        .lfsr(l64), .count(c64), .out_valid(v64), .done(d64), .wrapped(w64), .zero_seed(z64));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the run visible.
    task automatic do_start(input logic [3:0] s, input logic [3:0] p, input logic [7:0] lim);
        seed  = s;
        poly  = p;
        limit = lim;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [63:0] model_step(input logic [63:0] cur, input logic [63:0] p);
        logic [63:0] m;
        m = cur >> 1;
        if (cur[0]) m = m ^ {1'b1, p[62:0]};
        return m;
    endfunction

    typedef struct {
        logic       rdy;
        logic       v;
        logic [3:0] l;
        logic [7:0] c;
        logic       d;
    } vec_t;

    vec_t        tbl [10];
    logic [3:0]  seq [15];
    logic [63:0] m64;

    initial begin
        // Backpressure run: seed 1, poly 4, limit 5, ready low for three cycles after the 2nd transfer.
        tbl[0] = '{1'b1, 1'b1, 4'h1, 8'd0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 4'hC, 8'd1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 4'h6, 8'd2, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 4'h6, 8'd2, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 4'h6, 8'd2, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 4'h6, 8'd2, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 4'h3, 8'd3, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 4'hD, 8'd4, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 4'hA, 8'd5, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 4'hA, 8'd5, 1'b1};
        seq = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};

        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
        seed = '0; poly = '0; limit = '0;
        start64 = 1'b0; abort64 = 1'b0; ready64 = 1'b0;
        seed64 = '0; poly64 = '0; limit64 = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid", v4, 0);
        chk("reset_done", d4, 0);
        chk("reset_lfsr", l4, 0);
        chk("reset_count", c4, 0);
        chk("reset_zero", z4, 0);
        rst = 1'b0;
        @(negedge clk);

        // limit=3: four values then done
        ready = 1'b1;
        do_start(4'h1, 4'h4, 8'd3);
        for (int k = 0; k < 4; k++) begin
            chk("lim3_valid", v4, 1);
            chk("lim3_lfsr", l4, seq[k]);
            chk("lim3_count", c4, k);
            @(negedge clk);
        end
        chk("lim3_done", d4, 1);
        chk("lim3_valid_low", v4, 0);
        chk("lim3_wrapped", w4, 0);

        // Wrap detection over the full period; free-running instance repeats from seed
        do_start(4'h1, 4'h4, 8'd100);
        for (int k = 0; k < 15; k++) begin
            chk("wrap_valid", v4, 1);
            chk("wrap_lfsr", l4, seq[k]);
            chk("wrap_count", c4, k);
            chk("nowrap_lfsr", l4n, seq[k]);
            @(negedge clk);
        end
        chk("wrap_done", d4, 1);
        chk("wrap_wrapped", w4, 1);
        chk("wrap_valid_low", v4, 0);
        chk("wrap_hold_lfsr", l4, 4'h2);
        chk("wrap_hold_count", c4, 14);
        chk("nowrap_repeat_lfsr", l4n, 4'h1);
        chk("nowrap_repeat_count", c4n, 15);
        chk("nowrap_still_valid", v4n, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_clears_done", d4, 0);
        chk("abort_clears_wrapped", w4, 0);
        chk("abort_drops_valid", v4n, 0);

        // limit=0: exactly one transfer
        do_start(4'h1, 4'h4, 8'd0);
        chk("lim0_valid", v4, 1);
        chk("lim0_lfsr", l4, 4'h1);
        chk("lim0_count", c4, 0);
        @(negedge clk);
        chk("lim0_done", d4, 1);
        chk("lim0_valid_low", v4, 0);
        chk("lim0_wrapped", w4, 0);

        // Backpressure table
        do_start(4'h1, 4'h4, 8'd5);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", v4, tbl[i].v);
            chk("bp_lfsr", l4, tbl[i].l);
            chk("bp_count", c4, tbl[i].c);
            chk("bp_done", d4, tbl[i].d);
            ready = tbl[i].rdy;
            @(negedge clk);
        end

        // Zero seed refusal, then a normal restart; start during RUN ignored
        ready = 1'b1;
        do_start(4'h0, 4'h4, 8'd3);
        chk("zero_done", d4, 1);
        chk("zero_flag", z4, 1);
        chk("zero_valid", v4, 0);
        @(negedge clk);
        chk("zero_valid_later", v4, 0);
        do_start(4'h1, 4'h4, 8'd2);
        chk("restart_valid", v4, 1);
        chk("restart_lfsr", l4, 4'h1);
        chk("restart_zero_clr", z4, 0);
        chk("restart_done_clr", d4, 0);
        do_start(4'h5, 4'h4, 8'd9);
        chk("run_start_ign_lfsr", l4, 4'hC);
        chk("run_start_ign_count", c4, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // Abort at count=4, asserted together with start
        do_start(4'h1, 4'h4, 8'd100);
        repeat (4) @(negedge clk);
        chk("pre_abort_count", c4, 4);
        chk("pre_abort_lfsr", l4, 4'hD);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_valid", v4, 0);
        chk("abort_done", d4, 0);
        @(negedge clk);
        chk("abort_beats_start", v4, 0);

        // Asynchronous reset between edges
        do_start(4'h1, 4'h4, 8'd100);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", v4, 0);
        chk("async_rst_lfsr", l4, 0);
        chk("async_rst_count", c4, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("async_rst_done", d4, 0);

        // 64-bit run against a software Galois model, 1000 values
        seed64  = 64'h0123_4567_89AB_CDEF;
        poly64  = 64'hD800_0000_0000_001B;
        limit64 = 64'd999;
        ready64 = 1'b1;
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        m64 = seed64;
        for (int k = 0; k < 1000; k++) begin
            chk("w64_lfsr", l64, m64);
            chk("w64_count", c64, k);
            m64 = model_step(m64, poly64);
            @(negedge clk);
        end
        chk("w64_done", d64, 1);
        chk("w64_valid_low", v64, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_stream_gen.md
# lfsr_stream_gen

Parametrised Galois (internal-XOR) LFSR message generator feeding the DES cracking datapath with one candidate value per handshake. It replaces the fixed 64-bit pause-driven generator with a generic-width design, a valid/ready output handshake for backpressure, an index output, zero-seed protection and optional early termination when the sequence wraps back to its seed. It sits between the job controller, which supplies seed, polynomial and limit, and the DES unit's message input.

## Interface
- WIDTH, 64, LFSR width (≥ 2)
- CNT_WIDTH, 64, width of counter_limit and count
- STOP_ON_WRAP, 1, when 1 the run ends early if the next state equals the seed
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  pulse; capture seed/polynomial/counter_limit and begin a run (accepted in IDLE or DONE)
- abort  in  1  terminate the current run, return to IDLE
- seed  in  WIDTH  initial LFSR state
- polynomial  in  WIDTH  tap mask; bit WIDTH-1 ignored
- counter_limit  in  CNT_WIDTH  index of the last value emitted
- out_ready  in  1  downstream accepts the current value
- lfsr  out  WIDTH  current LFSR value
- count  out  CNT_WIDTH  index of the current value (0 = seed)
- out_valid  out  1  lfsr/count are valid
- done  out  1  run finished; held until start or abort
- wrapped  out  1  run ended by wrap detection (valid while done)
- zero_seed  out  1  run refused because seed was all-zero (valid while done)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; lfsr, count, seed/poly/limit registers = 0; out_valid, done, wrapped, zero_seed = 0.
- Step function: fb = cur[0]; next[i] = polynomial_reg[i] ? cur[i+1]^fb : cur[i+1] for i < WIDTH-1; next[WIDTH-1] = fb.
- IDLE/DONE + start: latch seed, polynomial, counter_limit; lfsr ← seed; count ← 0; clear wrapped, zero_seed, done. If seed == 0 → DONE with zero_seed = 1; else → RUN.
- RUN: out_valid = 1. On out_valid & out_ready (a transfer):
  - count == limit_reg → DONE, wrapped = 0; lfsr/count hold the last value.
  - else STOP_ON_WRAP && next == seed_reg → DONE, wrapped = 1.
  - else lfsr ← next, count ← count + 1.
- No transfer (out_ready = 0): lfsr and count hold; no value skipped or duplicated.
- Limit check has priority over wrap check when both hold on the same transfer (wrapped = 0).
- count arithmetic is modulo 2^CNT_WIDTH; with STOP_ON_WRAP = 0 and limit ≥ period the sequence repeats from the seed.
- start while in RUN is ignored.
- abort in any state → IDLE next edge; out_valid drops; done/wrapped/zero_seed clear. abort with start in the same cycle: abort wins.
- DONE: out_valid = 0, done = 1 until start (restart) or abort.

## Timing
- start sampled at edge N → out_valid = 1 with lfsr = seed, count = 0 from edge N+1.
- Throughput: one value per cycle while out_ready = 1.
- Final transfer at edge M → done = 1 and out_valid = 0 from edge M+1.
- Zero seed: done = 1, zero_seed = 1 from edge N+1; out_valid never asserts.
- Number of values emitted without early stop = counter_limit + 1.
- rst asserted mid-run: all outputs to reset values immediately, independent of clk.
- All outputs decoded from registers only; no combinational path from out_ready to out_valid.

## Test plan
- WIDTH=4, seed=4'h1, poly=4'h4, limit=3, ready=1 → lfsr 1,C,6,3 with count 0..3 on consecutive cycles; done next cycle, wrapped=0.
- Same, limit=100, STOP_ON_WRAP=1 → 15 values 1,C,6,3,D,A,5,E,7,F,B,9,8,4,2; last count=14; done with wrapped=1.
- Same with limit=0 → exactly one transfer (lfsr=1, count=0), then done.
- Backpressure: limit=5, out_ready low for 3 cycles after the second transfer → lfsr held at 6, count=2; resumes 6,3,D,A with no skips.
- seed=0 → done=1, zero_seed=1 one cycle after start; out_valid stays 0; start with seed=1 afterwards runs normally.
- Mid-run abort at count=4 → IDLE next edge, out_valid=0, done=0; async rst pulsed between clock edges → outputs reset immediately; WIDTH=64 run with an arbitrary 64-bit polynomial matches a software Galois model over 1000 steps.
